mc_controller: RTL and testbench

Multicycle control FSM that sequences the shared MIPS datapath (single memory, instruction register, ALU, ALUOut/Data registers) through fetch, decode, execute, memory and writeback steps. It supports the same instruction set as the single-cycle/pipelined decoders: R-type ADD/SUB/AND/OR/SLT, LW, SW, BEQ, BNE, ADDI, ORI and J. Memory-access states wait on a ready handshake. Undecodable instructions park the FSM in a trap state.

---
 rtl/mc_controller.sv | 173 +++++++++++++++++
 tb/tb_mc_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared datapath; memory states stall on memready, bad encodings trap.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       immext,
    output logic [2:0] alucontrol,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       retire,
    output logic       illegal
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE,
        ALUWB, BRANCH, IMMEX, IMMWB, JUMP, TRAP
    } state_t;

    state_t     state;
    logic       funct_ok;
    logic [2:0] rfunc_alu;

    always_comb begin
        funct_ok  = 1'b1;
        rfunc_alu = ALU_ADD;
        case (funct)
            6'b100000: rfunc_alu = ALU_ADD;
            6'b100010: rfunc_alu = ALU_SUB;
            6'b100100: rfunc_alu = ALU_AND;
            6'b100101: rfunc_alu = ALU_OR;
            6'b101010: rfunc_alu = ALU_SLT;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:   if (memready) state <= DECODE;
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW:   state <= MEMADR;
                        OP_RTYPE:       state <= funct_ok ? EXECUTE : TRAP;
                        OP_BEQ, OP_BNE: state <= BRANCH;
                        OP_ADDI, OP_ORI: state <= IMMEX;
                        OP_J:           state <= JUMP;
                        default:        state <= TRAP;
                    endcase
                end
                MEMADR:  state <= (op == OP_LW) ? MEMRD : MEMWR;
                MEMRD:   if (memready) state <= MEMWB;
                MEMWR:   if (memready) state <= FETCH;
                EXECUTE: state <= ALUWB;
                BRANCH:  state <= FETCH;
                IMMEX:   state <= IMMWB;
                MEMWB, ALUWB, IMMWB, JUMP: state <= FETCH;
                TRAP:    state <= TRAP;
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        immext     = 1'b0;
        alucontrol = ALU_ADD;
        pcsrc      = 2'b00;
        pcen       = 1'b0;
        retire     = 1'b0;
        illegal    = 1'b0;
        case (state)
            FETCH: begin
                alusrcb = 2'b01;
                irwrite = memready;
                pcen    = memready;
            end
            DECODE:  alusrcb = 2'b11;
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD:   iord = 1'b1;
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                retire   = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                retire   = memready;
            end
            EXECUTE: begin
                alusrca    = 1'b1;
                alucontrol = rfunc_alu;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                retire   = 1'b1;
            end
            BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                pcen       = (op == OP_BNE) ? ~zero : zero;
                retire     = 1'b1;
            end
            IMMEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                immext     = (op == OP_ORI);
                alucontrol = (op == OP_ORI) ? ALU_OR : ALU_ADD;
            end
            IMMWB: begin
                regwrite = 1'b1;
                retire   = 1'b1;
            end
            JUMP: begin
                pcsrc  = 2'b10;
                pcen   = 1'b1;
                retire = 1'b1;
            end
            TRAP:    illegal = 1'b1;
            default: ;
        endcase
        // reset forces FETCH, but memready must not leak into the enables meanwhile
        if (reset) begin
            irwrite  = 1'b0;
            pcen     = 1'b0;
            regwrite = 1'b0;
            memwrite = 1'b0;
            retire   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboarded bench for mc_controller: driver pushes per-cycle control vectors
// and instruction lengths; a negedge monitor pops and compares.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, memready;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       immext, pcen, retire, illegal;
    logic [2:0] alucontrol;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .memready(memready), .iord(iord), .memwrite(memwrite),
        .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .immext(immext), .alucontrol(alucontrol), .pcsrc(pcsrc),
        .pcen(pcen), .retire(retire), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef enum int {
        P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR, P_EXEC,
        P_ALUWB, P_BRANCH, P_IMMEX, P_IMMWB, P_JUMP, P_TRAP
    } phase_t;

    typedef struct packed {
        logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
        logic [1:0] alusrcb;
        logic       immext;
        logic [2:0] alucontrol;
        logic [1:0] pcsrc;
        logic       pcen, retire, illegal;
    } ctl_t;

    localparam logic [5:0] LW = 6'h23, SW = 6'h2b, BEQ = 6'h04, BNE = 6'h05;
    localparam logic [5:0] ADDI = 6'h08, ORI = 6'h0d, JMP = 6'h02;

    ctl_t act;
    assign act = '{iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                   alusrcb, immext, alucontrol, pcsrc, pcen, retire, illegal};

    ctl_t exp_q[$];
    int   len_q[$];
    int   n_chk = 0, n_pass = 0, cyc = 0;
    bit   done = 0;

    // Expected Moore/Mealy outputs for one cycle spent in a given step
    function automatic ctl_t model(phase_t p, logic [5:0] o, logic [5:0] f, logic z, logic mr);
        ctl_t c;
        c = '0;
        c.alucontrol = 3'b010;
        case (p)
            P_FETCH:  begin c.alusrcb = 2'b01; c.irwrite = mr; c.pcen = mr; end
            P_DECODE: c.alusrcb = 2'b11;
            P_MEMADR: begin c.alusrca = 1; c.alusrcb = 2'b10; end
            P_MEMRD:  c.iord = 1;
            P_MEMWB:  begin c.memtoreg = 1; c.regwrite = 1; c.retire = 1; end
            P_MEMWR:  begin c.iord = 1; c.memwrite = 1; c.retire = mr; end
            P_EXEC: begin
                c.alusrca = 1;
                c.alucontrol = (f == 6'h22) ? 3'b110 : (f == 6'h24) ? 3'b000 :
                               (f == 6'h25) ? 3'b001 : (f == 6'h2a) ? 3'b111 : 3'b010;
            end
            P_ALUWB:  begin c.regdst = 1; c.regwrite = 1; c.retire = 1; end
            P_BRANCH: begin
                c.alusrca = 1; c.alucontrol = 3'b110; c.pcsrc = 2'b01; c.retire = 1;
                c.pcen = (o == BEQ) ? z : !z;
            end
            P_IMMEX: begin
                c.alusrca = 1; c.alusrcb = 2'b10;
                c.immext = (o == ORI);
                c.alucontrol = (o == ORI) ? 3'b001 : 3'b010;
            end
            P_IMMWB:  begin c.regwrite = 1; c.retire = 1; end
            P_JUMP:   begin c.pcsrc = 2'b10; c.pcen = 1; c.retire = 1; end
            default:  c.illegal = 1;
        endcase
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, a, e);
    endtask

    always @(negedge clk) begin
        ctl_t e;
        if (reset) begin
            chk("reset_ctl", 32'(act), 32'(model(P_FETCH, 6'h0, 6'h0, 1'b0, 1'b0)));
            exp_q.delete();
            len_q.delete();
            cyc = 0;
        end else if (done) begin
            chk("drain", exp_q.size() + len_q.size(), 0);
        end else begin
            if (exp_q.size() == 0) chk("exp_underflow", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("ctl", 32'(act), 32'(e));
            end
            cyc++;
            if (retire) begin
                if (len_q.size() == 0) chk("spurious_retire", 1, 0);
                else chk("latency", cyc, len_q.pop_front());
                cyc = 0;
            end
        end
    end

    // Drive one instruction; fw/mw = stall cycles in FETCH / memory step,
    // abort = cycle index at which reset hits mid-cycle (-1 none), ntrap = TRAP cycles
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int fw,
                             input int mw, input logic zb, input int abort, input int ntrap);
        phase_t path[$];
        bit     trap, memph;
        int     w, k, n;
        logic   mr, z;
        path = '{P_FETCH, P_DECODE};
        trap = 0;
        if (o == LW) path = {path, P_MEMADR, P_MEMRD, P_MEMWB};
        else if (o == SW) path = {path, P_MEMADR, P_MEMWR};
        else if (o == 6'h00 && f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a})
            path = {path, P_EXEC, P_ALUWB};
        else if (o == BEQ || o == BNE) path.push_back(P_BRANCH);
        else if (o == ADDI || o == ORI) path = {path, P_IMMEX, P_IMMWB};
        else if (o == JMP) path.push_back(P_JUMP);
        else begin
            trap = 1;
            for (int i = 0; i < ntrap; i++) path.push_back(P_TRAP);
        end
        if (!trap) begin
            n = path.size() + fw + ((o == LW || o == SW) ? mw : 0);
            len_q.push_back(n);
        end
        op = o;
        funct = f;
        k = 0;
        foreach (path[i]) begin
            memph = path[i] inside {P_FETCH, P_MEMRD, P_MEMWR};
            w = !memph ? 0 : (path[i] == P_FETCH) ? fw : mw;
            for (int j = 0; j <= w; j++) begin
                mr = memph ? (j == w) : 1'($urandom % 2);
                z = (path[i] == P_BRANCH) ? zb : 1'($urandom % 2);
                memready = mr;
                zero = z;
                exp_q.push_back(model(path[i], o, f, z, mr));
                if (k == abort) begin
                    #2 reset = 1;
                    memready = 1;
                    @(posedge clk);
                    #1 reset = 0;
                    return;
                end
                @(posedge clk);
                #1 k++;
            end
        end
    endtask

    task automatic do_reset();
        #2 reset = 1;
        memready = 1;
        @(posedge clk);
        #1 reset = 0;
    endtask

    initial begin
        logic [5:0] ops [12];
        logic [5:0] fns [12];
        int s;
        ops = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, LW, SW, BEQ, BNE, ADDI, ORI, JMP};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h11, 6'h07, 6'h3f, 6'h00, 6'h15, 6'h2a, 6'h01};
        reset = 1; memready = 1; op = 0; funct = 0; zero = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;

        run_instr(6'h00, 6'h20, 0, 0, 0, -1, 0);
        run_instr(LW,   6'h00, 0, 0, 0, -1, 0);
        run_instr(SW,   6'h00, 0, 0, 0, -1, 0);
        run_instr(ADDI, 6'h00, 0, 0, 0, -1, 0);
        run_instr(JMP,  6'h00, 0, 0, 0, -1, 0);
        run_instr(LW,   6'h00, 2, 3, 0, -1, 0);
        run_instr(BEQ,  6'h00, 0, 0, 1, -1, 0);
        run_instr(BEQ,  6'h00, 0, 0, 0, -1, 0);
        run_instr(BNE,  6'h00, 0, 0, 0, -1, 0);
        run_instr(BNE,  6'h00, 0, 0, 1, -1, 0);
        run_instr(ORI,  6'h00, 1, 0, 0, -1, 0);
        run_instr(ADDI, 6'h00, 0, 0, 0, -1, 0);
        run_instr(SW,   6'h00, 1, 2, 0, -1, 0);

        for (int i = 0; i < 60; i++) begin
            s = $urandom_range(0, 11);
            run_instr(ops[s], fns[s], $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom % 2), -1, 0);
        end

        run_instr(LW, 6'h00, 0, 5, 0, 4, 0);
        run_instr(6'h00, 6'h25, 0, 0, 0, -1, 0);
        run_instr(SW, 6'h00, 0, 4, 0, 4, 0);
        run_instr(6'h00, 6'h2a, 0, 0, 0, -1, 0);

        run_instr(6'h3f, 6'h20, 0, 0, 0, -1, 24);
        do_reset();
        run_instr(6'h00, 6'h22, 0, 0, 0, -1, 0);
        run_instr(6'h00, 6'h00, 1, 0, 0, -1, 22);
        do_reset();
        run_instr(ORI, 6'h00, 0, 0, 0, -1, 0);

        done = 1;
        @(negedge clk);
        #1 $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
